count_monitor: RTL and testbench

Downstream checker for the free-running up-counter. It samples the counter's output bus every clock and verifies that each value is the previous value plus one, modulo 2^WIDTH. After the counter's own reset it instead expects zero. Results are reported as registered status: lock indication, error pulse, saturating error count, capture of the first offending value, and a wrap-around pulse. It sits beside the counter in the testbench top level and in any design that reuses the counter as a timebase.

---
 rtl/count_monitor_if.sv | 35 +++
 rtl/count_monitor.sv | 146 ++++++++++++++
 tb/tb_count_monitor.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/count_monitor_if.sv
// ---------------------------------------------------------------------------
// count_monitor_if : monitored-counter bus and checker status  | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface count_monitor_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 16
);
  logic                 en;
  logic [WIDTH-1:0]     cnt_in;
  logic                 cnt_rst;
  logic                 clr_err;
  logic                 locked;
  logic                 err_pulse;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] error_count;
  logic [WIDTH-1:0]     bad_value;
  logic [WIDTH-1:0]     bad_expected;
  logic                 wrap_pulse;

  modport master (
    output en, cnt_in, cnt_rst, clr_err,
    input  locked, err_pulse, err_sticky, error_count,
           bad_value, bad_expected, wrap_pulse
  );

  modport slave (
    input  en, cnt_in, cnt_rst, clr_err,
    output locked, err_pulse, err_sticky, error_count,
           bad_value, bad_expected, wrap_pulse
  );
endinterface

`default_nettype wire

// File: rtl/count_monitor.sv
// ---------------------------------------------------------------------------
// count_monitor : checks a free-running up-counter for +1 steps  | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module count_monitor #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 16,
  parameter int LOCK_N    = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  count_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACQ   = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam logic [7:0] c_LOCK_N = 8'(LOCK_N);

  state_t               r_state;
  logic [WIDTH-1:0]     r_prev;
  logic                 r_rst_d;
  logic [7:0]           r_good_run;
  logic                 r_locked;
  logic                 r_err_pulse;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_error_count;
  logic [WIDTH-1:0]     r_bad_value;
  logic [WIDTH-1:0]     r_bad_expected;
  logic                 r_wrap_pulse;

  state_t               w_state_nxt;
  logic [WIDTH-1:0]     w_prev_nxt;
  logic [7:0]           w_good_run_nxt;
  logic                 w_locked_nxt;
  logic                 w_err_pulse_nxt;
  logic                 w_err_sticky_nxt;
  logic [ERR_CNT_W-1:0] w_error_count_nxt;
  logic [WIDTH-1:0]     w_bad_value_nxt;
  logic [WIDTH-1:0]     w_bad_expected_nxt;
  logic                 w_wrap_pulse_nxt;
  logic [WIDTH-1:0]     w_expected;
  logic                 w_match;

  // A counter reset seen on the previous edge means the counter now reads 0.
  assign w_expected = r_rst_d ? '0 : r_prev + WIDTH'(1);
  assign w_match    = (mon.cnt_in == w_expected);

  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_good_run_nxt   = r_good_run;
    w_locked_nxt     = r_locked;
    w_err_pulse_nxt  = 1'b0;
    w_wrap_pulse_nxt = 1'b0;
    // The clear is applied before any mismatch on the same edge.
    w_err_sticky_nxt   = mon.clr_err ? 1'b0 : r_err_sticky;
    w_error_count_nxt  = mon.clr_err ? '0   : r_error_count;
    w_bad_value_nxt    = mon.clr_err ? '0   : r_bad_value;
    w_bad_expected_nxt = mon.clr_err ? '0   : r_bad_expected;

    if (!mon.en) begin
      w_state_nxt    = S_IDLE;
      w_locked_nxt   = 1'b0;
      w_good_run_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQ;
        end
        S_ACQ: begin
          w_prev_nxt     = mon.cnt_in;
          w_good_run_nxt = '0;
          w_locked_nxt   = 1'b0;
          w_state_nxt    = S_CHECK;
        end
        S_CHECK: begin
          // Always resync to the sampled value so one jump costs one error.
          w_prev_nxt = mon.cnt_in;
          if (w_match) begin
            w_good_run_nxt   = (r_good_run >= c_LOCK_N) ? c_LOCK_N : r_good_run + 8'd1;
            w_locked_nxt     = (w_good_run_nxt == c_LOCK_N);
            w_wrap_pulse_nxt = !r_rst_d && (r_prev == '1) && (mon.cnt_in == '0);
          end else begin
            w_err_pulse_nxt = 1'b1;
            w_good_run_nxt  = '0;
            w_locked_nxt    = 1'b0;
            if (!w_err_sticky_nxt) begin
              w_bad_value_nxt    = mon.cnt_in;
              w_bad_expected_nxt = w_expected;
            end
            w_err_sticky_nxt = 1'b1;
            if (w_error_count_nxt != '1)
              w_error_count_nxt = w_error_count_nxt + ERR_CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_prev         <= '0;
      r_rst_d        <= 1'b0;
      r_good_run     <= '0;
      r_locked       <= 1'b0;
      r_err_pulse    <= 1'b0;
      r_err_sticky   <= 1'b0;
      r_error_count  <= '0;
      r_bad_value    <= '0;
      r_bad_expected <= '0;
      r_wrap_pulse   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_prev         <= w_prev_nxt;
      r_rst_d        <= mon.cnt_rst;
      r_good_run     <= w_good_run_nxt;
      r_locked       <= w_locked_nxt;
      r_err_pulse    <= w_err_pulse_nxt;
      r_err_sticky   <= w_err_sticky_nxt;
      r_error_count  <= w_error_count_nxt;
      r_bad_value    <= w_bad_value_nxt;
      r_bad_expected <= w_bad_expected_nxt;
      r_wrap_pulse   <= w_wrap_pulse_nxt;
    end
  end

  assign mon.locked       = r_locked;
  assign mon.err_pulse    = r_err_pulse;
  assign mon.err_sticky   = r_err_sticky;
  assign mon.error_count  = r_error_count;
  assign mon.bad_value    = r_bad_value;
  assign mon.bad_expected = r_bad_expected;
  assign mon.wrap_pulse   = r_wrap_pulse;

endmodule

`default_nettype wire

// File: tb/tb_count_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_monitor : directed scoreboard bench for count_monitor  | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_count_monitor;

  localparam int WIDTH     = 8;
  localparam int ERR_CNT_W = 4;
  localparam int LOCK_N    = 4;

  typedef struct packed {
    logic                 locked;
    logic                 err_pulse;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] error_count;
    logic [WIDTH-1:0]     bad_value;
    logic [WIDTH-1:0]     bad_expected;
    logic                 wrap_pulse;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  count_monitor_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  count_monitor #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W), .LOCK_N(LOCK_N)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_wrap   = 0;
  int n_errp   = 0;
  obs_t sb_q[$];

  // Reference model state: 0 idle, 1 acquire, 2 checking.
  int               m_state = 0;
  logic [WIDTH-1:0] m_prev  = '0;
  logic             m_rstd  = 1'b0;
  int               m_run   = 0;
  obs_t             m       = '0;
  logic [WIDTH-1:0] ctr     = '0;

  function automatic obs_t observe();
    obs_t o;
    o.locked       = bus.locked;
    o.err_pulse    = bus.err_pulse;
    o.err_sticky   = bus.err_sticky;
    o.error_count  = bus.error_count;
    o.bad_value    = bus.bad_value;
    o.bad_expected = bus.bad_expected;
    o.wrap_pulse   = bus.wrap_pulse;
    return o;
  endfunction

  task automatic model_edge();
    logic [WIDTH-1:0] exp_v;
    if (rst) begin
      m_state = 0; m_prev = '0; m_rstd = 1'b0; m_run = 0; m = '0;
    end else begin
      m.err_pulse  = 1'b0;
      m.wrap_pulse = 1'b0;
      if (bus.clr_err) begin
        m.error_count = '0; m.err_sticky = 1'b0; m.bad_value = '0; m.bad_expected = '0;
      end
      if (!bus.en) begin
        m_state = 0; m.locked = 1'b0; m_run = 0;
      end else if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        m_prev = bus.cnt_in; m_run = 0; m.locked = 1'b0; m_state = 2;
      end else begin
        exp_v = m_rstd ? 8'h00 : 8'(m_prev + 8'h01);
        if (bus.cnt_in == exp_v) begin
          if (m_run < LOCK_N) m_run++;
          m.locked     = (m_run == LOCK_N);
          m.wrap_pulse = !m_rstd && (m_prev == 8'hFF) && (bus.cnt_in == 8'h00);
        end else begin
          m.err_pulse = 1'b1;
          if (!m.err_sticky) begin
            m.bad_value = bus.cnt_in; m.bad_expected = exp_v;
          end
          m.err_sticky = 1'b1;
          if (m.error_count != 4'hF) m.error_count++;
          m_run = 0; m.locked = 1'b0;
        end
        m_prev = bus.cnt_in;
      end
      m_rstd = bus.cnt_rst;
    end
    sb_q.push_back(m);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    obs_t e, o;
    model_edge();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = observe();
    if (o.wrap_pulse === 1'b1) n_wrap++;
    if (o.err_pulse === 1'b1) n_errp++;
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL scoreboard t=%0t observed=%h expected=%h", $time, o, e);
    end
  endtask

  task automatic count(input int n);
    repeat (n) begin
      bus.cnt_in = ctr;
      cyc();
      ctr = ctr + 8'h01;
    end
  endtask

  int e0, w0;

  initial begin
    bus.en = 1'b0; bus.cnt_in = '0; bus.cnt_rst = 1'b0; bus.clr_err = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    check("reset_outputs", 32'(observe()), 32'h0);

    // Clean run and lock latency
    rst = 1'b0; bus.en = 1'b1; ctr = '0;
    count(LOCK_N + 1);
    check("lock_early", 32'(bus.locked), 32'h0);
    count(1);
    check("lock_edge", 32'(bus.locked), 32'h1);
    count(1000);
    check("clean_errcnt", 32'(bus.error_count), 32'h0);
    check("clean_locked", 32'(bus.locked), 32'h1);

    // Single skip: 0,1,2,3 then 5 instead of 4
    bus.cnt_rst = 1'b1; bus.cnt_in = ctr; cyc(); bus.cnt_rst = 1'b0;
    ctr = '0; count(4);
    e0 = n_errp;
    bus.cnt_in = 8'd5; cyc();
    check("skip_pulse",  32'(bus.err_pulse), 32'h1);
    check("skip_errcnt", 32'(bus.error_count), 32'h1);
    check("skip_badval", 32'(bus.bad_value), 32'd5);
    check("skip_badexp", 32'(bus.bad_expected), 32'd4);
    check("skip_unlock", 32'(bus.locked), 32'h0);
    ctr = 8'd6; count(LOCK_N - 1);
    check("skip_relock_early", 32'(bus.locked), 32'h0);
    count(1);
    check("skip_relock", 32'(bus.locked), 32'h1);
    count(10);
    check("skip_one_error", 32'(n_errp - e0), 32'd1);
    bus.clr_err = 1'b1; bus.cnt_in = ctr; cyc(); ctr++; bus.clr_err = 1'b0;
    check("clr_sticky", 32'(bus.err_sticky), 32'h0);
    check("clr_errcnt", 32'(bus.error_count), 32'h0);

    // Wrap 254,255,0,1
    bus.cnt_in = 8'd252; cyc();
    ctr = 8'd253; bus.clr_err = 1'b1; bus.cnt_in = ctr; cyc(); ctr++; bus.clr_err = 1'b0;
    w0 = n_wrap;
    count(2);
    check("wrap_none_yet", 32'(n_wrap - w0), 32'd0);
    count(1);
    check("wrap_on_zero", 32'(bus.wrap_pulse), 32'h1);
    check("wrap_no_err", 32'(bus.err_pulse), 32'h0);
    count(1);
    check("wrap_once", 32'(n_wrap - w0), 32'd1);
    check("wrap_errcnt", 32'(bus.error_count), 32'h0);

    // Counter reset at 37: following 0 is neither error nor wrap
    count(35);
    bus.cnt_rst = 1'b1; bus.cnt_in = 8'd37; cyc(); bus.cnt_rst = 1'b0;
    ctr = '0; count(1);
    check("crst_no_err",  32'(bus.err_pulse), 32'h0);
    check("crst_no_wrap", 32'(bus.wrap_pulse), 32'h0);
    check("crst_errcnt",  32'(bus.error_count), 32'h0);

    // Stuck reset: counter reset requested but output stays at 9
    bus.cnt_rst = 1'b1; bus.cnt_in = ctr; cyc(); bus.cnt_rst = 1'b0;
    bus.cnt_in = 8'd9; cyc();
    check("stuck_pulse",  32'(bus.err_pulse), 32'h1);
    check("stuck_badexp", 32'(bus.bad_expected), 32'd0);
    check("stuck_badval", 32'(bus.bad_value), 32'd9);

    // Saturation then clear coinciding with a mismatch
    repeat (20) cyc();
    check("sat_errcnt", 32'(bus.error_count), 32'hF);
    bus.clr_err = 1'b1; cyc(); bus.clr_err = 1'b0;
    check("clr_mis_errcnt", 32'(bus.error_count), 32'h1);
    check("clr_mis_sticky", 32'(bus.err_sticky), 32'h1);
    check("clr_mis_badval", 32'(bus.bad_value), 32'd9);
    check("clr_mis_badexp", 32'(bus.bad_expected), 32'd10);

    // en falling in CHECK
    bus.cnt_rst = 1'b1; cyc(); bus.cnt_rst = 1'b0;
    ctr = '0; count(LOCK_N);
    check("en_pre_locked", 32'(bus.locked), 32'h1);
    bus.en = 1'b0; bus.cnt_in = ctr; cyc();
    check("en_off_unlock", 32'(bus.locked), 32'h0);
    check("en_off_errcnt", 32'(bus.error_count), 32'h2);
    check("en_off_sticky", 32'(bus.err_sticky), 32'h1);

    // Reset mid-run while locked with three errors
    bus.en = 1'b1; count(2);
    bus.cnt_in = ctr + 8'd5; cyc(); ctr = ctr + 8'd6;
    count(LOCK_N);
    check("pre_rst_locked", 32'(bus.locked), 32'h1);
    check("pre_rst_errcnt", 32'(bus.error_count), 32'h3);
    rst = 1'b1; bus.cnt_in = ctr; cyc(); rst = 1'b0;
    check("midrst_outputs", 32'(observe()), 32'h0);
    count(LOCK_N + 1);
    check("relock_early", 32'(bus.locked), 32'h0);
    count(1);
    check("relock_edge", 32'(bus.locked), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
